// File: rtl/rr_multi_gnt_arb.sv
// rr_multi_gnt_arb
//   Registered multi-grant arbiter. Each unstalled cycle it picks up to REQS
//   requesters out of WIDTH request lines. The search runs either from index 0
//   (fixed priority) or from a rotating pointer (round-robin). It registers one
//   one-hot grant slot per pick.
//
// Ports
//   clock    : sole clock, rising edge
//   reset_n  : asynchronous active-low reset
//   req      : request lines, sampled on the rising edge
//   rr_en    : 1 = round-robin from ptr, 0 = fixed lowest-index-first
//   stall    : 1 = hold every register, ignore req
//   gnt_bus  : slot j at [(j+1)*WIDTH-1 -: WIDTH], one-hot or zero
//   gnt      : OR of all slots
//   gnt_cnt  : number of non-zero slots
//   empty    : 1 when no grant was issued
//   ptr      : current round-robin priority pointer
module rr_multi_gnt_arb #(
    parameter int WIDTH = 8,
    parameter int REQS  = 2,
    parameter int PTR_W = $clog2(WIDTH),
    parameter int CNT_W = $clog2(REQS + 1)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [WIDTH-1:0]        req,
    input  logic                    rr_en,
    input  logic                    stall,
    output logic [WIDTH*REQS-1:0]   gnt_bus,
    output logic [WIDTH-1:0]        gnt,
    output logic [CNT_W-1:0]        gnt_cnt,
    output logic                    empty,
    output logic [PTR_W-1:0]        ptr
);

    logic [REQS-1:0][WIDTH-1:0] gnt_bus_q, gnt_bus_d;
    logic [WIDTH-1:0]           gnt_q, gnt_d;
    logic [CNT_W-1:0]           gnt_cnt_q, gnt_cnt_d;
    logic                       empty_q, empty_d;
    logic [PTR_W-1:0]           ptr_q, ptr_d;

    // Selection scratch
    logic [REQS-1:0][WIDTH-1:0] slot;
    logic [CNT_W-1:0]           cnt;
    logic [PTR_W-1:0]           start;
    logic [PTR_W-1:0]           idx;
    logic [PTR_W-1:0]           last;
    logic [PTR_W:0]             sum;
    logic [WIDTH-1:0]           gnt_or;

    // Walk the request vector in search order. Each hit fills the next free
    // slot, so slot 0 is always the highest-priority grant. The index wraps by
    // explicit subtraction, which keeps a non-power-of-2 WIDTH in range.
    always_comb begin
        slot  = '0;
        cnt   = '0;
        last  = '0;
        sum   = '0;
        idx   = '0;
        start = rr_en ? ptr_q : '0;
        for (int k = 0; k < WIDTH; k++) begin
            sum = {1'b0, start} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(WIDTH))
                sum = sum - (PTR_W+1)'(WIDTH);
            idx = sum[PTR_W-1:0];
            if (req[idx] && (cnt < CNT_W'(REQS))) begin
                for (int j = 0; j < REQS; j++)
                    if (cnt == CNT_W'(j))
                        slot[j][idx] = 1'b1;
                last = idx;
                cnt  = cnt + CNT_W'(1);
            end
        end
        gnt_or = '0;
        for (int j = 0; j < REQS; j++)
            gnt_or = gnt_or | slot[j];
    end

    always_comb begin
        gnt_bus_d = gnt_bus_q;
        gnt_d     = gnt_q;
        gnt_cnt_d = gnt_cnt_q;
        empty_d   = empty_q;
        ptr_d     = ptr_q;
        if (!stall) begin
            gnt_bus_d = slot;
            gnt_d     = gnt_or;
            gnt_cnt_d = cnt;
            empty_d   = (cnt == '0);
            if (!rr_en)
                ptr_d = '0;
            else if (cnt != '0)
                // Resume one past the last requester served this cycle.
                ptr_d = (last == PTR_W'(WIDTH - 1)) ? '0 : last + PTR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gnt_bus_q <= '0;
            gnt_q     <= '0;
            gnt_cnt_q <= '0;
            empty_q   <= 1'b1;
            ptr_q     <= '0;
        end else begin
            gnt_bus_q <= gnt_bus_d;
            gnt_q     <= gnt_d;
            gnt_cnt_q <= gnt_cnt_d;
            empty_q   <= empty_d;
            ptr_q     <= ptr_d;
        end
    end

    assign gnt_bus = gnt_bus_q;
    assign gnt     = gnt_q;
    assign gnt_cnt = gnt_cnt_q;
    assign empty   = empty_q;
    assign ptr     = ptr_q;

endmodule

// File: tb/tb_rr_multi_gnt_arb.sv
// Directed bench for rr_multi_gnt_arb at WIDTH=8, REQS=2.
module tb_rr_multi_gnt_arb;

    localparam int WIDTH = 8;
    localparam int REQS  = 2;

    logic                  clock;
    logic                  reset_n;
    logic [WIDTH-1:0]      req;
    logic                  rr_en;
    logic                  stall;
    logic [WIDTH*REQS-1:0] gnt_bus;
    logic [WIDTH-1:0]      gnt;
    logic [1:0]            gnt_cnt;
    logic                  empty;
    logic [2:0]            ptr;

    int checks = 0;
    int errors = 0;

    rr_multi_gnt_arb #(.WIDTH(WIDTH), .REQS(REQS)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .rr_en   (rr_en),
        .stall   (stall),
        .gnt_bus (gnt_bus),
        .gnt     (gnt),
        .gnt_cnt (gnt_cnt),
        .empty   (empty),
        .ptr     (ptr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        checks++;
        if (gnt_bus !== 16'h0 || gnt !== 8'h0 || gnt_cnt !== 2'd0 || empty !== 1'b1 || ptr !== 3'd0) begin
            errors++;
            $display("FAIL reset_init: bus=%h gnt=%h cnt=%0d empty=%b ptr=%0d want 0/0/0/1/0", gnt_bus, gnt, gnt_cnt, empty, ptr);
        end
        reset_n = 1'b1;
        rr_en   = 1'b1;
        req     = 8'hFF;
        step();
        checks++;
        if (gnt_bus !== 16'h0201 || ptr !== 3'd2) begin
            errors++;
            $display("FAIL reset_release_sel: bus=%h ptr=%0d want 0201/2", gnt_bus, ptr);
        end
        // Assert reset between edges; outputs must clear without a clock.
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (gnt_bus !== 16'h0 || gnt !== 8'h0 || gnt_cnt !== 2'd0 || empty !== 1'b1 || ptr !== 3'd0) begin
            errors++;
            $display("FAIL reset_async: bus=%h gnt=%h cnt=%0d empty=%b ptr=%0d want 0/0/0/1/0", gnt_bus, gnt, gnt_cnt, empty, ptr);
        end
        @(negedge clock);
        reset_n = 1'b1;
        req     = 8'h00;
        rr_en   = 1'b0;
    endtask

    task automatic test_fixed();
        rr_en = 1'b0;
        req   = 8'b1011_0100;
        step();
        checks++;
        if (gnt_bus !== {8'b0001_0000, 8'b0000_0100} || gnt !== 8'b0001_0100 || gnt_cnt !== 2'd2 || empty !== 1'b0 || ptr !== 3'd0) begin
            errors++;
            $display("FAIL fixed: bus=%h gnt=%h cnt=%0d empty=%b ptr=%0d want 1004/14/2/0/0", gnt_bus, gnt, gnt_cnt, empty, ptr);
        end
    endtask

    task automatic test_rr_sweep();
        logic [15:0] exp_bus [4];
        logic [2:0]  exp_ptr [4];
        exp_bus[0] = 16'h0201; exp_ptr[0] = 3'd2;
        exp_bus[1] = 16'h0804; exp_ptr[1] = 3'd4;
        exp_bus[2] = 16'h2010; exp_ptr[2] = 3'd6;
        exp_bus[3] = 16'h8040; exp_ptr[3] = 3'd0;
        rr_en = 1'b1;
        req   = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (gnt_bus !== exp_bus[i] || ptr !== exp_ptr[i] || gnt_cnt !== 2'd2 || gnt !== (exp_bus[i][15:8] | exp_bus[i][7:0])) begin
                errors++;
                $display("FAIL rr_sweep[%0d]: bus=%h ptr=%0d cnt=%0d gnt=%h want bus=%h ptr=%0d cnt=2", i, gnt_bus, ptr, gnt_cnt, gnt, exp_bus[i], exp_ptr[i]);
            end
        end
    endtask

    task automatic test_wrap();
        rr_en = 1'b1;
        req   = 8'hFF;
        repeat (3) step();
        checks++;
        if (ptr !== 3'd6) begin
            errors++;
            $display("FAIL wrap_pre_ptr: ptr=%0d want 6", ptr);
        end
        req = 8'b0100_0001;
        step();
        checks++;
        if (gnt_bus !== {8'b0000_0001, 8'b0100_0000} || ptr !== 3'd1 || gnt !== 8'h41) begin
            errors++;
            $display("FAIL wrap: bus=%h ptr=%0d gnt=%h want 0140/1/41", gnt_bus, ptr, gnt);
        end
    endtask

    task automatic test_single_zero();
        req = 8'b0000_0001;
        step();
        checks++;
        if (gnt_bus !== 16'h0001 || gnt_cnt !== 2'd1 || empty !== 1'b0 || ptr !== 3'd1) begin
            errors++;
            $display("FAIL single: bus=%h cnt=%0d empty=%b ptr=%0d want 0001/1/0/1", gnt_bus, gnt_cnt, empty, ptr);
        end
        req = 8'h00;
        step();
        checks++;
        if (gnt_bus !== 16'h0 || gnt !== 8'h0 || gnt_cnt !== 2'd0 || empty !== 1'b1 || ptr !== 3'd1) begin
            errors++;
            $display("FAIL zero: bus=%h gnt=%h cnt=%0d empty=%b ptr=%0d want 0/0/0/1/1", gnt_bus, gnt, gnt_cnt, empty, ptr);
        end
    endtask

    task automatic test_stall();
        // From ptr=1, req 0x30 grants bits 4 then 5; ptr moves to 6.
        req = 8'h30;
        step();
        checks++;
        if (gnt_bus !== 16'h2010 || ptr !== 3'd6) begin
            errors++;
            $display("FAIL stall_setup: bus=%h ptr=%0d want 2010/6", gnt_bus, ptr);
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req = (i % 2 == 0) ? 8'hFF : 8'h0F;
            step();
            checks++;
            if (gnt_bus !== 16'h2010 || gnt !== 8'h30 || gnt_cnt !== 2'd2 || empty !== 1'b0 || ptr !== 3'd6) begin
                errors++;
                $display("FAIL stall_hold[%0d]: bus=%h gnt=%h cnt=%0d empty=%b ptr=%0d want 2010/30/2/0/6", i, gnt_bus, gnt, gnt_cnt, empty, ptr);
            end
        end
        stall = 1'b0;
        req   = 8'hFF;
        step();
        checks++;
        if (gnt_bus !== 16'h8040 || ptr !== 3'd0) begin
            errors++;
            $display("FAIL stall_resume: bus=%h ptr=%0d want 8040/0", gnt_bus, ptr);
        end
    endtask

    task automatic test_back_to_back();
        // Round-robin moves ptr, then fixed mode searches from 0 and clears ptr.
        rr_en = 1'b1;
        req   = 8'hFF;
        step();
        checks++;
        if (ptr !== 3'd2) begin
            errors++;
            $display("FAIL b2b_rr_ptr: ptr=%0d want 2", ptr);
        end
        rr_en = 1'b0;
        req   = 8'b1100_0001;
        step();
        checks++;
        if (gnt_bus !== 16'h4001 || ptr !== 3'd0 || gnt_cnt !== 2'd2) begin
            errors++;
            $display("FAIL b2b_fixed: bus=%h ptr=%0d cnt=%0d want 4001/0/2", gnt_bus, ptr, gnt_cnt);
        end
        // Stall together with rr_en change: nothing moves until stall drops.
        req   = 8'h0C;
        rr_en = 1'b1;
        stall = 1'b1;
        step();
        checks++;
        if (gnt_bus !== 16'h4001 || ptr !== 3'd0) begin
            errors++;
            $display("FAIL b2b_stall_rr: bus=%h ptr=%0d want 4001/0", gnt_bus, ptr);
        end
        stall = 1'b0;
        step();
        checks++;
        if (gnt_bus !== 16'h0804 || ptr !== 3'd4) begin
            errors++;
            $display("FAIL b2b_unstall_rr: bus=%h ptr=%0d want 0804/4", gnt_bus, ptr);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req     = '0;
        rr_en   = 1'b0;
        stall   = 1'b0;
        @(negedge clock);
        @(negedge clock);
        test_reset();
        test_fixed();
        test_rr_sweep();
        test_wrap();
        test_single_zero();
        test_stall();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_multi_gnt_arb.md
# rr_multi_gnt_arb

Registered, parametrised multi-grant arbiter for the issue and dispatch selection paths. Each cycle it picks up to REQS requesters out of WIDTH request lines. The search order is either fixed (lowest index wins) or round-robin from a rotating priority pointer. It returns one one-hot grant vector per grant slot plus their OR. Unlike a purely combinational priority selector, grants are registered, the pointer carries fairness state across cycles, and a stall input freezes the block.

## Interface
- WIDTH, 8: number of request lines; must be at least 2.
- REQS, 2: maximum grants per cycle; must satisfy 1 ≤ REQS ≤ WIDTH.
- PTR_W, $clog2(WIDTH): pointer width.
- CNT_W, $clog2(REQS+1): grant-count width.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  WIDTH  request lines, sampled on the rising edge.
- rr_en  in  1  1 selects round-robin order from ptr; 0 selects fixed lowest-index-first order.
- stall  in  1  1 holds every register and ignores req.
- gnt_bus  out  WIDTH*REQS  slot j occupies bits [(j+1)*WIDTH-1 -: WIDTH]; each slot is one-hot or zero.
- gnt  out  WIDTH  OR of all gnt_bus slots.
- gnt_cnt  out  CNT_W  number of non-zero slots.
- empty  out  1  1 when no grant was issued.
- ptr  out  PTR_W  current priority pointer (observable state).

## Operation
- Search start:
  - rr_en=1: the search starts at index ptr and proceeds ptr, ptr+1, …, WIDTH-1, 0, …, ptr-1.
  - rr_en=0: the search starts at index 0.
- Slot filling: slot j takes the j-th set bit of req found in search order.
  - Slots left unfilled (fewer set bits than REQS) are zero.
  - A requester never appears in two slots.
- Slot ordering: slot 0 is always the highest-priority grant; slot order follows search order, not index order.
- Derived outputs:
  - gnt equals the OR of all slots.
  - gnt_cnt equals the number of non-zero slots, ranging 0..REQS.
  - empty=1 exactly when gnt_cnt=0.
- Pointer update, applied only when stall=0:
  - rr_en=1 and gnt_cnt>0: ptr ← (index of the last filled slot + 1) mod WIDTH.
  - rr_en=1 and gnt_cnt=0: ptr holds.
  - rr_en=0: ptr ← 0.
- Wrap arithmetic: performed mod WIDTH explicitly, so a non-power-of-2 WIDTH never produces ptr ≥ WIDTH.
- Stall: when stall=1, gnt_bus, gnt, gnt_cnt, empty and ptr all hold their values.
- Simultaneous stall and rr_en change: stall wins; the rr_en change takes effect on the first unstalled edge.
- Reset values, applied while reset_n=0 and immediately on assertion (no clock edge needed):
  - gnt_bus=0, gnt=0, gnt_cnt=0, empty=1, ptr=0.
  - Reset asserted mid-operation discards pending selection state.

## Timing
- Latency from req to grant is 1 cycle: req sampled at edge N appears on the outputs after edge N.
- Pointer update: ptr updates on the same edge as the grants it derives from, and that value governs the selection at edge N+1.
- Output stability: all outputs come directly from registers; there is no combinational path from an input to any output.
- There is no request/grant handshake: the requester must hold req until it observes its grant bit. A grant for a request withdrawn after sampling is still issued.
- Reset release: the first edge with reset_n=1 performs a normal selection using ptr=0.

## Test plan
- Reset (WIDTH=8, REQS=2): assert reset_n=0 mid-stream between edges -> gnt_bus=0, gnt=0, gnt_cnt=0, empty=1, ptr=0 immediately, with no clock edge required.
- Fixed mode: rr_en=0, req=8'b1011_0100 -> next cycle slot0=8'b0000_0100, slot1=8'b0001_0000, gnt=8'b0001_0100, gnt_cnt=2, ptr=0.
- Round-robin sweep: rr_en=1, req=8'hFF held, starting from ptr=0 ->
  - cycle 1 grants bits {0,1}, ptr=2;
  - cycle 2 grants {2,3}, ptr=4;
  - cycle 3 grants {4,5}, ptr=6;
  - cycle 4 grants {6,7}, ptr=0.
- Wrap across index 0: with ptr=6 (after 3 sweep cycles), req=8'b0100_0001 -> slot0=8'b0100_0000, slot1=8'b0000_0001, ptr=1.
- Single and zero requests: with ptr=1, req=8'b0000_0001 -> slot0=8'b0000_0001, slot1=0, gnt_cnt=1, ptr=1. Then req=0 -> empty=1, gnt_cnt=0, ptr holds at 1.
- Stall: stall=1 for 3 cycles while req toggles between 8'hFF and 8'h0F -> all outputs and ptr unchanged. On the first edge after stall=0, selection resumes from the held ptr.
